// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle RV32I main controller and its datapath.
// master: the controller; slave: the datapath / memory side.
interface multicycle_control_fsm_if #(
  parameter int unsigned CNT_W = 32
);
  logic [6:0]       opcode_i;
  logic             mem_ready_i;
  logic             stall_i;
  logic             mem_req_o;
  logic             mem_we_o;
  logic             iord_o;
  logic             ir_write_o;
  logic             pc_write_o;
  logic [1:0]       alu_src_a_o;
  logic [1:0]       alu_src_b_o;
  logic [1:0]       alu_opmode_o;
  logic             reg_write_o;
  logic             mem_to_reg_o;
  logic             branch_o;
  logic             jump_o;
  logic             instr_done_o;
  logic             illegal_o;
  logic             timeout_o;
  logic [3:0]       state_o;
  logic [CNT_W-1:0] instret_o;

  modport master (
    input  opcode_i, mem_ready_i, stall_i,
    output mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o,
           alu_src_a_o, alu_src_b_o, alu_opmode_o, reg_write_o, mem_to_reg_o,
           branch_o, jump_o, instr_done_o, illegal_o, timeout_o, state_o, instret_o
  );

  modport slave (
    output opcode_i, mem_ready_i, stall_i,
    input  mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o,
           alu_src_a_o, alu_src_b_o, alu_opmode_o, reg_write_o, mem_to_reg_o,
           branch_o, jump_o, instr_done_o, illegal_o, timeout_o, state_o, instret_o
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I main control FSM: FETCH -> DECODE -> EXEC/MEM -> WB with
// memory handshake, wait-state timeout, global stall and illegal-opcode trap.
// Optional retired-instruction counter enabled by defining CTRL_INSTRET_EN.
module multicycle_control_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 32
) (
  input logic                       clk_i,
  input logic                       rst_ni,
  multicycle_control_fsm_if.master  bus
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    EXEC_I   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WR   = 4'd7,
    WB_MEM   = 4'd8,
    WB_ALU   = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    LUI      = 4'd12,
    TRAP     = 4'd13
  } state_e;

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  // Moore part of the outputs; ready/stall gating is applied after the register.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       fetch;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] opmode;
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic       done;
    logic       done_rdy;
  } ctl_t;

  function automatic ctl_t decode(input state_e s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.mem_req = 1'b1; c.fetch = 1'b1; c.src_b = 2'b01; end
      DECODE:   c.src_b = 2'b10;
      EXEC_R:   begin c.src_a = 2'b01; c.opmode = 2'b10; end
      EXEC_I:   begin c.src_a = 2'b01; c.src_b = 2'b10; c.opmode = 2'b11; end
      MEM_ADDR: begin c.src_a = 2'b01; c.src_b = 2'b10; end
      MEM_RD:   begin c.mem_req = 1'b1; c.iord = 1'b1; end
      MEM_WR:   begin c.mem_req = 1'b1; c.mem_we = 1'b1; c.iord = 1'b1; c.done_rdy = 1'b1; end
      WB_MEM:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.done = 1'b1; end
      WB_ALU:   begin c.reg_write = 1'b1; c.done = 1'b1; end
      BRANCH:   begin c.branch = 1'b1; c.src_a = 2'b01; c.opmode = 2'b01; c.done = 1'b1; end
      JUMP:     begin c.jump = 1'b1; c.reg_write = 1'b1; c.done = 1'b1; end
      LUI:      begin c.src_a = 2'b10; c.src_b = 2'b10; c.reg_write = 1'b1; c.done = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  state_e        state;
  state_e        nxt;
  ctl_t          ctl;
  logic [TW-1:0] wait_cnt;
  logic          illegal_q;
  logic          timeout_q;
  logic          set_ill;
  logic          set_to;
  logic          go;
  logic          ready;
  logic          done;

  assign go    = ~bus.stall_i;
  assign ready = bus.mem_ready_i;

  // Next-state selection, including timeout and illegal-opcode trap requests.
  always_comb begin
    nxt     = state;
    set_ill = 1'b0;
    set_to  = 1'b0;
    if (go) begin
      case (state)
        IDLE:     nxt = FETCH;
        FETCH, MEM_RD, MEM_WR: begin
          if (ready) begin
            nxt = (state == FETCH) ? DECODE : (state == MEM_RD) ? WB_MEM : FETCH;
          end else if (wait_cnt == T_LAST) begin
            nxt    = TRAP;
            set_to = 1'b1;
          end
        end
        DECODE: begin
          case (bus.opcode_i)
            7'b0110011:             nxt = EXEC_R;
            7'b0010011:             nxt = EXEC_I;
            7'b0000011, 7'b0100011: nxt = MEM_ADDR;
            7'b1100011:             nxt = BRANCH;
            7'b1101111, 7'b1100111: nxt = JUMP;
            7'b0110111:             nxt = LUI;
            default: begin
              nxt     = TRAP;
              set_ill = 1'b1;
            end
          endcase
        end
        EXEC_R, EXEC_I:        nxt = WB_ALU;
        MEM_ADDR:              nxt = bus.opcode_i[5] ? MEM_WR : MEM_RD;
        WB_MEM, WB_ALU, BRANCH, JUMP, LUI: nxt = FETCH;
        TRAP:                  nxt = TRAP;
        default: begin
          nxt     = TRAP;
          set_ill = 1'b1;
        end
      endcase
    end
  end

  // State, registered Moore decode (of the state being entered), wait counter and sticky flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      ctl       <= '0;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state <= nxt;
      ctl   <= decode(nxt);
      if (nxt != state) begin
        wait_cnt <= '0;
      end else if (go && ctl.mem_req && !ready) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (set_ill) illegal_q <= 1'b1;
      if (set_to)  timeout_q <= 1'b1;
    end
  end

  assign done = (ctl.done | (ctl.done_rdy & ready)) & go;

  assign bus.mem_req_o    = ctl.mem_req & go;
  assign bus.mem_we_o     = ctl.mem_we & go;
  assign bus.iord_o       = ctl.iord;
  assign bus.ir_write_o   = ctl.fetch & ready & go;
  assign bus.pc_write_o   = ((ctl.fetch & ready) | ctl.jump) & go;
  assign bus.alu_src_a_o  = ctl.src_a;
  assign bus.alu_src_b_o  = ctl.src_b;
  assign bus.alu_opmode_o = ctl.opmode;
  assign bus.reg_write_o  = ctl.reg_write & go;
  assign bus.mem_to_reg_o = ctl.mem_to_reg;
  assign bus.branch_o     = ctl.branch;
  assign bus.jump_o       = ctl.jump;
  assign bus.instr_done_o = done;
  assign bus.illegal_o    = illegal_q;
  assign bus.timeout_o    = timeout_q;
  assign bus.state_o      = state;

`ifdef CTRL_INSTRET_EN
  logic [CNT_W-1:0] instret;

  // Saturating count of retired instructions.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instret <= '0;
    end else if (done && (instret != '1)) begin
      instret <= instret + 1'b1;
    end
  end

  assign bus.instret_o = instret;
`else
  assign bus.instret_o = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: each step pushes the expected
// outputs to a scoreboard queue; a negedge checker pops and compares.
module tb_multicycle_control_fsm;

  localparam logic [3:0] S_IDLE = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2, S_EXEC_R = 4'd3,
                         S_EXEC_I = 4'd4, S_MEM_ADDR = 4'd5, S_MEM_RD = 4'd6, S_MEM_WR = 4'd7,
                         S_WB_MEM = 4'd8, S_WB_ALU = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11,
                         S_LUI = 4'd12, S_TRAP = 4'd13;

  typedef struct {
    logic [3:0]  st;
    logic [15:0] ctl;
    logic        ill;
    logic        to;
    logic [2:0]  ret;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  exp_t sb[$];
  exp_t ce;
  logic exp_ill;
  logic exp_to;
  logic [2:0] exp_ret;
  logic [15:0] obs_ctl;

  multicycle_control_fsm_if #(.CNT_W(3)) bus ();

  multicycle_control_fsm #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs_ctl = {bus.mem_req_o, bus.mem_we_o, bus.iord_o, bus.ir_write_o, bus.pc_write_o,
                    bus.alu_src_a_o, bus.alu_src_b_o, bus.alu_opmode_o, bus.reg_write_o,
                    bus.mem_to_reg_o, bus.branch_o, bus.jump_o, bus.instr_done_o};

  // Expected control vector written straight from the state table.
  function automatic logic [15:0] exp_ctl(input logic [3:0] s, input logic rdy, input logic stl);
    logic req = 0, we = 0, iord = 0, irw = 0, pcw = 0, rw = 0, m2r = 0, br = 0, jp = 0, dn = 0;
    logic [1:0] a = 2'b00, b = 2'b00, op = 2'b00;
    case (s)
      S_FETCH:    begin req = 1; b = 2'b01; irw = rdy; pcw = rdy; end
      S_DECODE:   b = 2'b10;
      S_EXEC_R:   begin a = 2'b01; op = 2'b10; end
      S_EXEC_I:   begin a = 2'b01; b = 2'b10; op = 2'b11; end
      S_MEM_ADDR: begin a = 2'b01; b = 2'b10; end
      S_MEM_RD:   begin req = 1; iord = 1; end
      S_MEM_WR:   begin req = 1; we = 1; iord = 1; dn = rdy; end
      S_WB_MEM:   begin rw = 1; m2r = 1; dn = 1; end
      S_WB_ALU:   begin rw = 1; dn = 1; end
      S_BRANCH:   begin br = 1; a = 2'b01; op = 2'b01; dn = 1; end
      S_JUMP:     begin jp = 1; rw = 1; pcw = 1; dn = 1; end
      S_LUI:      begin a = 2'b10; b = 2'b10; rw = 1; dn = 1; end
      default:    ;
    endcase
    if (stl) begin
      req = 0; we = 0; irw = 0; pcw = 0; rw = 0; dn = 0;
    end
    return {req, we, iord, irw, pcw, a, b, op, rw, m2r, br, jp, dn};
  endfunction

  // One clock cycle: drive inputs, queue expectation, advance to just after the next edge.
  task automatic cyc(input logic [3:0] s, input logic rdy, input logic stl);
    exp_t e;
    bus.mem_ready_i = rdy;
    bus.stall_i     = stl;
    e.st  = s;
    e.ctl = rst_n ? exp_ctl(s, rdy, stl) : 16'h0000;
    e.ill = exp_ill;
    e.to  = exp_to;
    e.ret = exp_ret;
    sb.push_back(e);
`ifdef CTRL_INSTRET_EN
    if (rst_n && e.ctl[0] && exp_ret != 3'd7) exp_ret = exp_ret + 3'd1;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    exp_ill = 1'b0;
    exp_to  = 1'b0;
    exp_ret = 3'd0;
    cyc(S_IDLE, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(S_IDLE, 1'b1, 1'b0);
  endtask

  // Scoreboard checker, sampling on the inactive edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      ce = sb.pop_front();
      n_checks++;
      assert (bus.state_o === ce.st) else begin
        n_errors++;
        $error("FAIL state: observed %0d expected %0d", bus.state_o, ce.st);
      end
      n_checks++;
      assert (obs_ctl === ce.ctl) else begin
        n_errors++;
        $error("FAIL ctl(state %0d): observed %04h expected %04h", ce.st, obs_ctl, ce.ctl);
      end
      n_checks++;
      assert (bus.illegal_o === ce.ill) else begin
        n_errors++;
        $error("FAIL illegal: observed %b expected %b", bus.illegal_o, ce.ill);
      end
      n_checks++;
      assert (bus.timeout_o === ce.to) else begin
        n_errors++;
        $error("FAIL timeout: observed %b expected %b", bus.timeout_o, ce.to);
      end
      n_checks++;
      assert (bus.instret_o === ce.ret) else begin
        n_errors++;
        $error("FAIL instret: observed %0d expected %0d", bus.instret_o, ce.ret);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    exp_ill = 1'b0;
    exp_to = 1'b0;
    exp_ret = 3'd0;
    bus.opcode_i = 7'b0110011;
    bus.mem_ready_i = 1'b0;
    bus.stall_i = 1'b0;
    @(posedge clk);
    #1;

    // R-type with ready tied high
    do_reset();
    cyc(S_FETCH, 1, 0); cyc(S_DECODE, 1, 0); cyc(S_EXEC_R, 1, 0); cyc(S_WB_ALU, 1, 0);

    // Load with three wait states (ready arrives at the timeout boundary)
    bus.opcode_i = 7'b0000011;
    cyc(S_FETCH, 1, 0); cyc(S_DECODE, 1, 0); cyc(S_MEM_ADDR, 0, 0);
    cyc(S_MEM_RD, 0, 0); cyc(S_MEM_RD, 0, 0); cyc(S_MEM_RD, 0, 0); cyc(S_MEM_RD, 1, 0);
    cyc(S_WB_MEM, 1, 0);

    // Store with a stall pulse during MEM_WR (ready ignored while stalled)
    bus.opcode_i = 7'b0100011;
    cyc(S_FETCH, 1, 0); cyc(S_DECODE, 1, 0); cyc(S_MEM_ADDR, 1, 0);
    cyc(S_MEM_WR, 0, 0); cyc(S_MEM_WR, 1, 1); cyc(S_MEM_WR, 0, 1); cyc(S_MEM_WR, 0, 0);
    cyc(S_MEM_WR, 1, 0);

    // Branch, with ready arriving on the last allowed FETCH wait cycle
    bus.opcode_i = 7'b1100011;
    cyc(S_FETCH, 0, 0); cyc(S_FETCH, 0, 0); cyc(S_FETCH, 0, 0); cyc(S_FETCH, 1, 0);
    cyc(S_DECODE, 0, 0); cyc(S_BRANCH, 0, 0);

    // JAL and LUI
    bus.opcode_i = 7'b1101111;
    cyc(S_FETCH, 1, 0); cyc(S_DECODE, 1, 0); cyc(S_JUMP, 1, 0);
    bus.opcode_i = 7'b0110111;
    cyc(S_FETCH, 1, 0); cyc(S_DECODE, 1, 0); cyc(S_LUI, 1, 0);

    // ADDI stream: stall in FETCH and WB_ALU, counter saturation
    bus.opcode_i = 7'b0010011;
    cyc(S_FETCH, 1, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(S_FETCH, 1, 0); cyc(S_DECODE, 1, 0); cyc(S_EXEC_I, 1, 0);
      cyc(S_WB_ALU, 1, 1); cyc(S_WB_ALU, 1, 0);
    end

    // Fetch timeout: four unacknowledged cycles then TRAP
    cyc(S_FETCH, 0, 0); cyc(S_FETCH, 0, 0); cyc(S_FETCH, 0, 0); cyc(S_FETCH, 0, 0);
    exp_to = 1'b1;
    cyc(S_TRAP, 1, 0); cyc(S_TRAP, 0, 0); cyc(S_TRAP, 1, 0);

    // Illegal opcode trap, then asynchronous reset clears it
    do_reset();
    bus.opcode_i = 7'b1111111;
    cyc(S_FETCH, 1, 0); cyc(S_DECODE, 1, 0);
    exp_ill = 1'b1;
    for (int k = 0; k < 20; k++) cyc(S_TRAP, k[0], 0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    assert (bus.illegal_o === 1'b0 && bus.state_o === S_IDLE) else begin
      n_errors++;
      $error("FAIL async_reset: observed illegal=%b state=%0d expected illegal=0 state=0",
             bus.illegal_o, bus.state_o);
    end
    @(posedge clk);
    #1;
    do_reset();
    bus.opcode_i = 7'b0110011;
    cyc(S_FETCH, 1, 0); cyc(S_DECODE, 1, 0);

    n_checks++;
    assert (sb.size() == 0) else begin
      n_errors++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
